// File: rtl/sigmoid_arbiter_if.sv
// -----------------------------------------------------------------------------
// sigmoid_arbiter_if
//
// Bundles the requester-side and result-side handshakes of sigmoid_arbiter.
//
// Signals:
//   req_valid [NREQ]     per-lane operand valid
//   req_x     [16*NREQ]  lane i operand at [16i+15:16i], signed Q4.12
//   req_ready [NREQ]     one-hot grant (or zero) back to the lanes
//   out_valid            result valid
//   out_ready            downstream accepts the result
//   out_data  [16]       activation, Q4.12, always in [0x0000, 0x1000]
//   out_id    [IDW]      lane that produced out_data
//
// Modports:
//   slave  - the arbiter itself (consumes operands, produces results)
//   master - the environment (lanes plus write-back path)
// -----------------------------------------------------------------------------
interface sigmoid_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_x;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_data;
    logic [IDW-1:0]       out_id;

    modport master (
        output req_valid, req_x, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_x, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/sigmoid_arbiter.sv
// -----------------------------------------------------------------------------
// sigmoid_arbiter
//
// Round-robin scheduler sharing one combinational sigmoid evaluator among NREQ
// neuron lanes. A granted Q4.12 operand is registered in S1, the shared
// sigmoid is evaluated from S1, and the saturated/clamped activation is
// registered in S2 together with the requester index.
//
// Parameters:
//   NREQ    number of requesting lanes (1..16)
//   IDW     width of the requester tag
//   SAT_TH  positive saturation threshold, Q4.12, must be > 0
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   bus     sigmoid_arbiter_if.slave (request and result handshakes)
// -----------------------------------------------------------------------------
module sigmoid_arbiter #(
    parameter int                 NREQ   = 4,
    parameter int                 IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter logic signed [15:0] SAT_TH = 16'sh2800
) (
    input  logic             clk,
    input  logic             rst,
    sigmoid_arbiter_if.slave bus
);

    // Lower threshold built one bit wider so negating SAT_TH cannot overflow.
    localparam logic signed [16:0] NEG_TH = -(17'(SAT_TH));

    // sigmoid(x) - 0.5 ~= x * (C_A + C_B*x^2 + C_C*x^4), coefficients in Q.16,
    // least-squares shaped to hit the true curve at x = 1.0, 2.0 and 2.5.
    localparam logic signed [47:0] C_A      = 48'sd16247;
    localparam logic signed [47:0] C_B      = -48'sd1159;
    localparam logic signed [47:0] C_C      = 48'sd54;
    localparam logic signed [47:0] HALF_Q12 = 48'sd2048;
    localparam logic signed [47:0] ONE_Q12  = 48'sd4096;

    // Shared sigmoid evaluator, Q4.12 in, unclamped Q.12 out.
    function automatic logic signed [47:0] sigmoid_poly(input logic signed [15:0] x);
        logic signed [47:0] xw;
        logic signed [47:0] x2;
        logic signed [47:0] acc;
        xw  = 48'(x);
        x2  = (xw * xw) >>> 12;        // x^2, Q.12
        acc = (C_C * x2) >>> 12;       // Horner, Q.16 throughout
        acc = C_B + acc;
        acc = (acc * x2) >>> 12;
        acc = C_A + acc;
        acc = (acc * xw) >>> 16;       // back to Q.12
        return HALF_Q12 + acc;
    endfunction

    // ---------------------------------------------------------------- state
    logic                     s1_valid;
    logic signed [15:0]       s1_x;
    logic [IDW-1:0]           s1_id;
    logic                     s2_valid;
    logic [15:0]              s2_data;
    logic [IDW-1:0]           s2_id;
    logic [IDW-1:0]           last;

    // ---------------------------------------------------------------- comb
    logic                     s2_free;
    logic                     s1_free;
    logic [15:0]              lane_x [NREQ];
    logic [NREQ-1:0]          grant;
    logic [IDW-1:0]           grant_id;
    logic [15:0]              grant_x;
    logic                     found;
    logic [IDW:0]             cand_sum;
    logic [IDW-1:0]           cand;
    logic                     accept;
    logic signed [47:0]       poly;
    logic [15:0]              act;

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign lane_x[g] = bus.req_x[16*g +: 16];
    end

    assign s2_free = !s2_valid || bus.out_ready;
    assign s1_free = !s1_valid || s2_free;

    // Round-robin search starting just after the last accepted lane.
    // NOTE: every variable assigned in an always_comb gets a default at the
    // top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        grant_x  = '0;
        found    = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_sum = {1'b0, last} + (IDW+1)'(k);
            if (cand_sum >= (IDW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IDW+1)'(NREQ);
            end
            cand = cand_sum[IDW-1:0];
            if (!found && bus.req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_id    = cand;
                grant_x     = lane_x[cand];
            end
        end
    end

    // Grant is offered only while S1 can take it; never during reset.
    assign bus.req_ready = (s1_free && !rst) ? grant : '0;
    assign accept        = found && s1_free && !rst;

    // Activation: hard saturation outside +/-SAT_TH, clamp the polynomial inside.
    always_comb begin
        poly = sigmoid_poly(s1_x);
        act  = '0;
        if (s1_x >= SAT_TH) begin
            act = 16'h1000;
        end else if (17'(s1_x) <= NEG_TH) begin
            act = 16'h0000;
        end else if (poly < 0) begin
            act = 16'h0000;
        end else if (poly > ONE_Q12) begin
            act = 16'h1000;
        end else begin
            act = poly[15:0];
        end
    end

    // ---------------------------------------------------------------- regs
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
            last     <= IDW'(NREQ - 1);
        end else begin
            if (s1_free) begin
                s1_valid <= accept;
            end
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= act;
                    s2_id   <= s1_id;
                end
            end
            if (accept) begin
                last <= grant_id;
            end
        end
    end

    // NOTE: the S1 operand/tag are qualified by s1_valid, so they carry no
    // reset; S2 data/tag are reset because they are visible on the outputs.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_x  <= grant_x;
            s1_id <= grant_id;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_id    = s2_id;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_arbiter
//
// Directed bench for sigmoid_arbiter (NREQ=4). A transaction-level model
// (round-robin pick, in-flight queue, ideal sigmoid from $exp) is checked
// against the DUT on every negative clock edge; directed sections add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_sigmoid_arbiter;

    localparam int NREQ = 4;
    localparam int SAT  = 10240;   // 2.5 in Q4.12
    localparam int TOL  = 12;      // LSB tolerance against the ideal sigmoid

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sigmoid_arbiter_if #(.NREQ(NREQ)) bus ();

    sigmoid_arbiter #(.NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input logic [31:0] got, input int lo, input int hi);
        checks++;
        if ($isunknown(got) || int'(got) < lo || int'(got) > hi) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h..0x%0h", name, got, lo, hi);
        end
    endtask

    // ------------------------------------------------------------ model
    typedef struct {
        int          id;
        logic [15:0] x;
        int          t;      // edge index at which the operand was captured
    } item_t;

    item_t q[$];
    int    m_last;
    int    edge_cnt;
    bit    live  = 1'b0;
    bit    fresh = 1'b0;

    function automatic int pick(input int last_i, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last_i + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [15:0] lane_of(input logic [16*NREQ-1:0] xs, input int g);
        logic [16*NREQ-1:0] sh;
        sh = xs >> (16 * g);
        return sh[15:0];
    endfunction

    task automatic exp_window(input logic [15:0] x, output int lo, output int hi);
        int  sx;
        real r;
        sx = int'($signed(x));
        if (sx >= SAT) begin
            lo = 4096; hi = 4096;
        end else if (sx <= -SAT) begin
            lo = 0; hi = 0;
        end else begin
            r  = 4096.0 / (1.0 + $exp(-real'(sx) / 4096.0));
            lo = int'(r) - TOL;
            hi = int'(r) + TOL;
            if (lo < 0)    lo = 0;
            if (hi > 4096) hi = 4096;
        end
    endtask

    // Compare process: inputs change at posedge+1, so at negedge both inputs
    // and outputs are settled for the coming edge.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        bit              exp_ov;
        bit              pop;
        bit              acc;
        int              g;
        int              lo;
        int              hi;
        exp_ov = 1'b0;
        g      = -1;
        exp_ready = '0;
        if (live) begin
            g = pick(m_last, bus.req_valid);
            if (!rst && g >= 0 && (q.size() < 2 || bus.out_ready)) exp_ready[g] = 1'b1;
            check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            exp_ov = (q.size() > 0) && (q[0].t < edge_cnt);
            check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            if (exp_ov) begin
                fresh = 1'b0;
                check("out_id", 32'(bus.out_id), 32'(q[0].id));
                exp_window(q[0].x, lo, hi);
                check_range("out_data", 32'(bus.out_data), lo, hi);
            end else if (fresh) begin
                check("out_data_after_reset", 32'(bus.out_data), 32'h0);
                check("out_id_after_reset", 32'(bus.out_id), 32'h0);
            end
        end
        if (rst) begin
            q.delete();
            m_last   = NREQ - 1;
            edge_cnt = 0;
            fresh    = 1'b1;
            live     = 1'b1;
        end else if (live) begin
            pop = exp_ov && bus.out_ready;
            acc = (exp_ready & bus.req_valid) != '0;
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back('{id: g, x: lane_of(bus.req_x, g), t: edge_cnt + 1});
                m_last = g;
            end
            edge_cnt++;
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [15:0] x);
        bus.req_x[16*i +: 16] = x;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] x;
        int          lo;
        int          hi;
    } vec_t;

    vec_t sat_vecs [9] = '{
        '{16'h7000, 4096, 4096},
        '{16'h8000,    0,    0},
        '{16'h2800, 4096, 4096},
        '{16'hD800,    0,    0},
        '{16'h1000, 16'h0BB0, 16'h0BC0},
        '{16'h27FF, 3770, 3800},
        '{16'hD801,  296,  326},
        '{16'hF000, 1090, 1112},
        '{16'h0800, 2540, 2560}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit got;
        bit a;
        int nacc;
        logic [15:0] sx;

        rst           = 1'b1;
        bus.req_valid = '1;          // ready must stay low during reset anyway
        bus.req_x     = '0;
        bus.out_ready = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_out_id",    32'(bus.out_id),    32'h0);

        // Single lane 0, x = 0.
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b0001;
        set_lane(0, 16'h0000);
        @(negedge clk);
        check("t1_req_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("t1_not_yet_valid", 32'(bus.out_valid), 32'h0);
        tick();
        @(negedge clk);
        check("t1_out_valid", 32'(bus.out_valid), 32'h1);
        check("t1_out_data",  32'(bus.out_data),  32'h0800);
        check("t1_out_id",    32'(bus.out_id),    32'h0);

        // Saturation / clamp on lane 2.
        foreach (sat_vecs[v]) begin
            tick();
            bus.req_valid = 4'b0100;
            set_lane(2, sat_vecs[v].x);
            got = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (bus.req_ready[2]) begin got = 1'b1; break; end
            end
            check("sat_accept", 32'(got), 32'h1);
            tick();
            bus.req_valid = '0;
            got = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (bus.out_valid) begin got = 1'b1; break; end
            end
            check("sat_out_valid", 32'(got), 32'h1);
            if (got) begin
                check_range($sformatf("sat_x_%04h", sat_vecs[v].x), 32'(bus.out_data),
                            sat_vecs[v].lo, sat_vecs[v].hi);
                check("sat_out_id", 32'(bus.out_id), 32'h2);
            end
        end

        // Fairness: all lanes valid, ids 0,1,2,3,... with no bubbles.
        do_reset();
        set_lane(0, 16'hE000);
        set_lane(1, 16'hF800);
        set_lane(2, 16'h0C00);
        set_lane(3, 16'h1C00);
        bus.req_valid = '1;
        got = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin got = 1'b1; break; end
        end
        check("fair_first_out", 32'(got), 32'h1);
        for (int k = 0; k < 8; k++) begin
            check("fair_out_valid", 32'(bus.out_valid), 32'h1);
            check($sformatf("fair_id_%0d", k), 32'(bus.out_id), 32'(k % 4));
            if (k < 7) @(negedge clk);
        end
        tick();
        bus.req_valid = '0;
        repeat (4) tick();

        // Backpressure on lane 1: exactly two accepts, then drain in order.
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0010;
        sx = 16'h0200;
        set_lane(1, sx);
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a = bus.req_valid[1] & bus.req_ready[1];
            if (a) nacc++;
            tick();
            if (a) begin sx = sx + 16'h0100; set_lane(1, sx); end
        end
        check("bp_accepts", 32'(nacc), 32'd2);
        @(negedge clk);
        check("bp_full_ready", 32'(bus.req_ready), 32'h0);
        check("bp_full_valid", 32'(bus.out_valid), 32'h1);
        tick();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            a = bus.req_valid[1] & bus.req_ready[1];
            tick();
            if (a) begin sx = sx + 16'h0100; set_lane(1, sx); end
        end
        bus.req_valid = '0;
        repeat (5) tick();
        @(negedge clk);
        check("bp_drained", 32'(bus.out_valid), 32'h0);

        // Sparse lanes 1 and 3 with last = 3, then lane 3 withdraws.
        do_reset();
        set_lane(1, 16'h0300);
        set_lane(3, 16'hFD00);
        bus.req_valid = 4'b1010;
        @(negedge clk);
        check("sparse_first", 32'(bus.req_ready), 32'b0010);
        tick();
        @(negedge clk);
        check("sparse_second", 32'(bus.req_ready), 32'b1000);
        tick();
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("sparse_solo_a", 32'(bus.req_ready), 32'b0010);
        tick();
        @(negedge clk);
        check("sparse_solo_b", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = '0;
        repeat (4) tick();

        // Reset with S1 and S2 full.
        bus.out_ready = 1'b0;
        bus.req_valid = '1;
        repeat (3) tick();
        @(negedge clk);
        check("rm_full_ready", 32'(bus.req_ready), 32'h0);
        check("rm_full_valid", 32'(bus.out_valid), 32'h1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rm_ready_in_reset", 32'(bus.req_ready), 32'h0);
        tick();
        @(negedge clk);
        check("rm_out_valid", 32'(bus.out_valid), 32'h0);
        check("rm_req_ready", 32'(bus.req_ready), 32'h0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rm_lane0_first", 32'(bus.req_ready), 32'h1);
        repeat (3) tick();
        bus.req_valid = '0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
